// File: rtl/hsid_pkg.sv
// Shared types and default widths for the HSID iterative divider.
// Optional build macro consumed by hsid_param_div: HSID_DIV_ROUND_EN.
package hsid_pkg;

  localparam int HSID_DATA_WIDTH_ACC  = 40;
  localparam int HSID_HSP_BANDS_WIDTH = 7;

  typedef enum logic [2:0] {
    HID_IDLE    = 3'd0,
    HID_COMPUTE = 3'd1,
    HID_CHECK   = 3'd2,
    HID_DONE    = 3'd3,
    HID_CLEAR   = 3'd4
  } hsid_ite_div_state_t;

endpackage

// File: rtl/hsid_div_step.sv
// One combinational restoring shift-subtract step of the divider.
// It brings in the next dividend bit, then subtracts the divisor when it fits.
module hsid_div_step #(
  parameter int DIVISOR_WIDTH = 7
) (
  input  logic [DIVISOR_WIDTH-1:0] rem_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  input  logic                     bit_i,
  output logic [DIVISOR_WIDTH-1:0] rem_o,
  output logic                     q_o
);

  logic [DIVISOR_WIDTH:0] w_partial;
  logic [DIVISOR_WIDTH:0] w_divisor;

  assign w_partial = {rem_i, bit_i};
  assign w_divisor = {1'b0, divisor_i};

  // rem_i < divisor keeps the partial below 2*divisor, so whichever path is taken fits back into DIVISOR_WIDTH bits
  assign q_o   = (w_partial >= w_divisor);
  assign rem_o = q_o ? DIVISOR_WIDTH'(w_partial - w_divisor)
                     : DIVISOR_WIDTH'(w_partial);

endmodule

// File: rtl/hsid_param_div.sv
// Iterative restoring unsigned divider that retires BITS_PER_CYCLE quotient bits per cycle.
// Define HSID_DIV_ROUND_EN to round the quotient to nearest, saturating at all ones.
module hsid_param_div
  import hsid_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = HSID_DATA_WIDTH_ACC,
  parameter int DIVISOR_WIDTH  = HSID_HSP_BANDS_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  remainder_o,
  output logic                      div_by_zero_o
);

  localparam int                  N_STEPS    = DIVIDEND_WIDTH / BITS_PER_CYCLE;
  localparam int                  CNT_W      = $clog2(N_STEPS + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(N_STEPS);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(1);

  hsid_ite_div_state_t r_state;
  hsid_ite_div_state_t w_state_next;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [DIVIDEND_WIDTH-1:0] r_work;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [CNT_W-1:0]          r_count;
  logic [DIVIDEND_WIDTH-1:0] r_quotient;
  logic [DIVISOR_WIDTH-1:0]  r_remainder;
  logic                      r_dbz;

  logic                      w_divisor_zero;
  logic [DIVISOR_WIDTH-1:0]  w_rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_qbits;
  logic [DIVIDEND_WIDTH-1:0] w_work_next;
  logic [DIVIDEND_WIDTH-1:0] w_q_final;

  assign w_divisor_zero = (divisor_i == '0);

  assign w_rem_chain[0] = r_rem;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    hsid_div_step #(
      .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_step (
      .rem_i     (w_rem_chain[g]),
      .divisor_i (r_divisor),
      .bit_i     (r_work[DIVIDEND_WIDTH-1-g]),
      .rem_o     (w_rem_chain[g+1]),
      .q_o       (w_qbits[BITS_PER_CYCLE-1-g])
    );
  end

  assign w_work_next = (r_work << BITS_PER_CYCLE) | DIVIDEND_WIDTH'(w_qbits);

`ifdef HSID_DIV_ROUND_EN
  logic [DIVISOR_WIDTH:0] w_rem_x2;
  logic                   w_round_up;

  assign w_rem_x2   = {r_rem, 1'b0};
  assign w_round_up = (w_rem_x2 >= {1'b0, r_divisor}) && (r_work != {DIVIDEND_WIDTH{1'b1}});
  assign w_q_final  = r_work + DIVIDEND_WIDTH'(w_round_up);
`else
  assign w_q_final  = r_work;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= HID_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: defaulting every combinational output before the case prevents latch inference.
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = HID_CLEAR;
    end else begin
      case (r_state)
        HID_IDLE:    if (start_i) w_state_next = w_divisor_zero ? HID_DONE : HID_COMPUTE;
        HID_COMPUTE: if (r_count == CNT_LAST) w_state_next = HID_CHECK;
        HID_CHECK:   w_state_next = HID_DONE;
        HID_DONE:    w_state_next = HID_IDLE;
        HID_CLEAR:   w_state_next = HID_IDLE;
        default:     w_state_next = HID_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!rst_ni) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (clear_i || (r_state == HID_CLEAR)) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        HID_IDLE: begin
          if (start_i) begin
            if (w_divisor_zero) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
            end else begin
              r_work    <= dividend_i;
              r_divisor <= divisor_i;
              r_rem     <= '0;
              r_count   <= CNT_LOAD;
              r_dbz     <= 1'b0;
            end
          end
        end
        HID_COMPUTE: begin
          r_work  <= w_work_next;
          r_rem   <= w_rem_chain[BITS_PER_CYCLE];
          r_count <= r_count - CNT_LAST;
        end
        HID_CHECK: begin
          r_quotient  <= w_q_final;
          r_remainder <= r_rem;
        end
        default: ;
      endcase
    end
  end

  assign ready_o       = (r_state == HID_IDLE);
  assign valid_o       = (r_state == HID_DONE) && !clear_i;
  assign quotient_o    = r_quotient;
  assign remainder_o   = r_remainder;
  assign div_by_zero_o = r_dbz;

endmodule

// File: doc/hsid_param_div.md
HSID_PARAM_DIV -- requirements
Module: hsid_param_div

Interface
REQ-001 Parameter DIVIDEND_WIDTH, default HSID_DATA_WIDTH_ACC (40), width of dividend and quotient.
REQ-002 Parameter DIVISOR_WIDTH, default HSID_HSP_BANDS_WIDTH (7), width of divisor and remainder.
REQ-003 Parameter BITS_PER_CYCLE, default 1, quotient bits retired per COMPUTE cycle; legal values 1, 2 or 4, and it SHALL divide DIVIDEND_WIDTH.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 clear_i  in  1  synchronous abort/flush; priority over start_i.
REQ-007 start_i  in  1  request division; sampled only while ready_o=1.
REQ-008 dividend_i  in  DIVIDEND_WIDTH  unsigned dividend, captured with start_i.
REQ-009 divisor_i  in  DIVISOR_WIDTH  unsigned divisor, captured with start_i.
REQ-010 ready_o  out  1  high only in HID_IDLE.
REQ-011 valid_o  out  1  one-cycle result strobe, high only in HID_DONE.
REQ-012 quotient_o  out  DIVIDEND_WIDTH  result quotient.
REQ-013 remainder_o  out  DIVISOR_WIDTH  result remainder.
REQ-014 div_by_zero_o  out  1  result flag; divisor was zero.

Function
REQ-015 FSM SHALL use hsid_ite_div_state_t: HID_IDLE, HID_COMPUTE, HID_CHECK, HID_DONE, HID_CLEAR.
REQ-016 IDLE, start_i=1, divisor_i!=0: capture operands, clear div_by_zero_o, load N=DIVIDEND_WIDTH/BITS_PER_CYCLE into step counter, go COMPUTE.
REQ-017 IDLE, start_i=1, divisor_i=0: go DONE next cycle; quotient_o all ones, remainder_o 0, div_by_zero_o 1.
REQ-018 COMPUTE: each cycle perform BITS_PER_CYCLE restoring shift-subtract steps MSB-first; partial remainder DIVISOR_WIDTH+1 bits; counter decrements; after N cycles go CHECK.
REQ-019 CHECK: one cycle; finalise quotient/remainder (rounding per REQ-030); go DONE.
REQ-020 DONE: valid_o=1 for exactly one cycle; go IDLE.
REQ-021 Latency: start_i sampled at edge t, valid_o high during cycle t+N+2; divide-by-zero valid_o high during cycle t+1.
REQ-022 quotient_o, remainder_o and div_by_zero_o SHALL hold their last result from DONE until the next accepted start_i or clear.
REQ-023 start_i outside IDLE SHALL be ignored, no queuing.
REQ-024 clear_i=1 in any state: next state CLEAR, valid_o 0 that cycle onward; CLEAR zeroes operands, counter and all result outputs, then IDLE unconditionally; start_i during CLEAR ignored.
REQ-025 Results SHALL be exact: dividend = quotient*divisor + remainder, remainder < divisor.

Reset
REQ-026 rst_ni low: state HID_IDLE, ready_o 1, valid_o 0, quotient_o 0, remainder_o 0, div_by_zero_o 0, counter 0, asynchronously.
REQ-027 Reset mid-COMPUTE SHALL discard the operation; no valid_o is produced for it.

Configuration
REQ-028 Macro HSID_DIV_ROUND_EN selects round-to-nearest.
REQ-029 Without it: CHECK passes the truncated quotient unchanged.
REQ-030 With it: in CHECK, if 2*remainder >= divisor, quotient +1, saturating at all ones; remainder_o keeps the unrounded remainder; divide-by-zero path unaffected.

Structure
REQ-031 hsid_pkg SHALL hold hsid_ite_div_state_t and default width constants; no new typedef local to the module.
REQ-032 One sub-module hsid_div_step: combinational single restoring step (partial remainder, divisor, next dividend bit -> new remainder, quotient bit), instantiated BITS_PER_CYCLE times in a chain.

Verification
REQ-033 Defaults, 1000/7 -> quotient 142, remainder 6, valid_o at cycle t+42; with HSID_DIV_ROUND_EN quotient 143, remainder 6.
REQ-034 1234/0 -> valid_o at t+1, quotient 0xFF_FFFF_FFFF, remainder 0, div_by_zero_o 1.
REQ-035 (2^40-1)/1 -> quotient 2^40-1, remainder 0; with rounding, no overflow, quotient unchanged.
REQ-036 BITS_PER_CYCLE=2, 100/3 -> quotient 33, remainder 1, valid_o at t+22; start_i pulsed mid-COMPUTE ignored.
REQ-037 clear_i at cycle t+10 of 1000/7 -> CLEAR at t+11, outputs 0, ready_o 1 at t+12, no valid_o; rst_ni low mid-COMPUTE -> immediate IDLE, outputs 0.
